// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cntWidth(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/seq_multiplier_add_w.sv
// add_w: W-bit ripple-carry adder with carry-out, one full adder per bit.
module add_w #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: W-bit operands, 2W-bit product over W cycles.
// Optional two's-complement mode enabled by defining SEQ_MUL_SIGNED_EN.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic           signed_op,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    localparam int CW = cntWidth(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic           carryOut;
    logic [2*W-1:0] accShift;

`ifdef SEQ_MUL_SIGNED_EN
    localparam logic [W-1:0]   ONE_W  = W'(1);
    localparam logic [2*W-1:0] ONE_2W = (2 * W)'(1);
    logic sign_q, sign_d;
`endif

    assign addend = acc_q[0] ? mcand_q : '0;

    add_w #(.W(W)) u_add (
        .x    (acc_q[2*W-1:W]),
        .y    (addend),
        .sum  (sum),
        .cout (carryOut)
    );

    // Carry, sum and the untouched low half shift right together as one word.
    assign accShift = {carryOut, sum, acc_q[W-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef SEQ_MUL_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    acc_d   = {{W{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef SEQ_MUL_SIGNED_EN
                    sign_d = 1'b0;
                    if (signed_op) begin
                        sign_d = a[W-1] ^ b[W-1];
                        if (a[W-1]) mcand_d = ~a + ONE_W;
                        if (b[W-1]) acc_d = {{W{1'b0}}, ~b + ONE_W};
                    end
`endif
                end
            end
            CALC: begin
                acc_d = accShift;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
`ifdef SEQ_MUL_SIGNED_EN
                    if (sign_q) acc_d = ~accShift + ONE_2W;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // Partial sums never leak onto product outside DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = out_valid ? acc_q : '0;

endmodule
